adv_timer_apb_arbiter: RTL
==========================

ADV_TIMER_APB_ARBITER -- requirements
Module: adv_timer_apb_arbiter

Interface
REQ-001 The block SHALL have parameter APB_ADDR_WIDTH, default 12, the APB address width toward the timer.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum number of ACCESS cycles before forced termination.
REQ-003 HCLK  in  1  sole clock; all state SHALL change on its rising edge.
REQ-004 HRESET  in  1  asynchronous, active-high reset.
REQ-005 reqN_i  in  1  (N=0,1) transfer request; held high until doneN_o.
REQ-006 reqN_addr_i  in  APB_ADDR_WIDTH  target register address.
REQ-007 reqN_wdata_i  in  32  write data.
REQ-008 reqN_write_i  in  1  1=write, 0=read.
REQ-009 doneN_o  out  1  one-cycle completion pulse.
REQ-010 reqN_rdata_o  out  32  read data, valid while doneN_o=1.
REQ-011 reqN_err_o  out  1  error flag, valid while doneN_o=1.
REQ-012 PADDR, PWDATA, PWRITE, PSEL, PENABLE  out  APB_ADDR_WIDTH/32/1/1/1  APB master toward the timer slave.
REQ-013 PRDATA, PREADY, PSLVERR  in  32/1/1  APB slave response.
REQ-014 busy_o  out  1  high in SETUP or ACCESS.

Function
REQ-015 The block SHALL implement FSM states IDLE, SETUP, ACCESS; all outputs registered.
REQ-016 IDLE: a requester with reqN_i=1 and doneN_o=0 is eligible; with any eligible requester, the FSM SHALL grant one, latch its addr/wdata/write, and enter SETUP next cycle.
REQ-017 Both eligible: grant the requester not granted last (round-robin); after reset the pointer SHALL favour requester 0.
REQ-018 SETUP: PSEL=1, PENABLE=0, PADDR/PWDATA/PWRITE = latched values; always advances to ACCESS after one cycle.
REQ-019 ACCESS: PSEL=1, PENABLE=1, address/data/write held stable; FSM stays until PREADY=1 or timeout.
REQ-020 PREADY=1 sampled in ACCESS: next cycle FSM SHALL be IDLE, PSEL=PENABLE=0, doneN_o=1 for the granted requester only, reqN_err_o=PSLVERR, reqN_rdata_o=PRDATA for reads and 0 for writes.
REQ-021 Minimum latency: request sampled in cycle 0 -> SETUP cycle 1 -> ACCESS cycle 2 -> doneN_o cycle 3 (zero-wait slave).
REQ-022 A 5-bit-or-wider wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with PREADY=0.
REQ-023 Counter reaching TIMEOUT_CYCLES with PREADY=0: transfer SHALL terminate as in REQ-020 with reqN_err_o=1, reqN_rdata_o=0.
REQ-024 PREADY=1 in the cycle the timeout is reached SHALL count as normal completion, not timeout.
REQ-025 Changes on request fields after grant SHALL have no effect on the ongoing transfer.
REQ-026 reqN_i dropped before doneN_o SHALL NOT abort the transfer; doneN_o still issues.
REQ-027 A requester holding reqN_i high across doneN_o SHALL be re-eligible from the following IDLE cycle (back-to-back; earliest next SETUP two cycles after previous done).
REQ-028 PREADY/PSLVERR/PRDATA outside ACCESS SHALL be ignored.
REQ-029 At most one APB transfer SHALL be outstanding; doneN_o SHALL never assert for both requesters in one cycle.

Reset
REQ-030 HRESET=1 SHALL asynchronously force IDLE, PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, doneN_o=0, reqN_rdata_o=0, reqN_err_o=0, busy_o=0, wait counter=0, round-robin pointer favouring requester 0.
REQ-031 Reset mid-transfer SHALL drop PSEL/PENABLE immediately and SHALL produce no done pulse for the aborted transfer.

Verification
REQ-032 req0 write addr 0x004 data 0xA5A5_0001, PREADY=1 -> SETUP cycle 1, ACCESS cycle 2, done0_o cycle 3, err=0, rdata=0.
REQ-033 req1 read addr 0x010, slave PREADY after 3 wait cycles PRDATA=0x0000_1234 -> ACCESS lasts 4 cycles, done1_o with rdata 0x0000_1234, err=0.
REQ-034 req0 and req1 both high from reset, held -> grants alternate 0,1,0,1; no cycle with both done.
REQ-035 PREADY held 0 with TIMEOUT_CYCLES=16 -> ACCESS lasts 16 cycles, done with err=1, rdata=0, PSEL deasserts.
REQ-036 PSLVERR=1 with PREADY=1 on a write -> done with err=1.
REQ-037 HRESET pulsed during ACCESS -> PSEL/PENABLE 0 same cycle, no done, next request granted to req0 on tie.

Source files
------------

// File: rtl/adv_timer_apb_arbiter.sv
// adv_timer_apb_arbiter: round-robin arbiter giving two requesters access to one APB timer slave
// Ports:
//   HCLK, HRESET                              clock, asynchronous active-high reset
//   reqN_i, reqN_addr_i, reqN_wdata_i,
//   reqN_write_i                              transfer request N (held until doneN_o)
//   doneN_o, reqN_rdata_o, reqN_err_o         one-cycle completion pulse with read data / error
//   PADDR, PWDATA, PWRITE, PSEL, PENABLE      APB master outputs toward the timer
//   PRDATA, PREADY, PSLVERR                   APB slave response
//   busy_o                                    high while in SETUP or ACCESS
module adv_timer_apb_arbiter #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req0_i,
  input  logic [APB_ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [31:0]               req0_wdata_i,
  input  logic                      req0_write_i,
  output logic                      done0_o,
  output logic [31:0]               req0_rdata_o,
  output logic                      req0_err_o,
  input  logic                      req1_i,
  input  logic [APB_ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [31:0]               req1_wdata_i,
  input  logic                      req1_write_i,
  output logic                      done1_o,
  output logic [31:0]               req1_rdata_o,
  output logic                      req1_err_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  output logic                      busy_o
);
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 5) ? $clog2(TIMEOUT_CYCLES + 1) : 5;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q;
  logic                      gnt_q, prio_q;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]               wdata_q;
  logic                      write_q;
  logic                      psel_q, psel_d, penable_q, penable_d;
  logic                      done0_q, done1_q, err0_q, err1_q;
  logic [31:0]               rdata0_q, rdata1_q;
  logic                      elig0, elig1, pick1, timeout, finish, fin_err;
  logic [31:0]               fin_rdata;
  // a requester whose done pulse is showing is not eligible, which gives back-to-back spacing
  assign elig0 = req0_i & ~done0_q;
  assign elig1 = req1_i & ~done1_q;
  // prio_q=1 means requester 1 wins a tie
  assign pick1 = elig1 & (~elig0 | prio_q);
  // the last wait cycle that still fits the budget; PREADY in that cycle wins over timeout
  assign timeout = ~PREADY & (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign finish = (state_q == ACCESS) & (PREADY | timeout);
  assign fin_err = PREADY ? PSLVERR : 1'b1;
  assign fin_rdata = (PREADY & ~write_q) ? PRDATA : 32'h0;
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = (state_q == IDLE)  ? ((elig0 | elig1) ? SETUP : IDLE) :
              (state_q == SETUP) ? ACCESS :
              finish             ? IDLE : ACCESS;
  always_comb begin
    psel_d = state_d != IDLE;
    penable_d = state_d == ACCESS;
  end
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      psel_q <= 1'b0;
      penable_q <= 1'b0;
      cnt_q <= '0;
      gnt_q <= 1'b0;
      prio_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      psel_q <= psel_d;
      penable_q <= penable_d;
      if (state_q == IDLE && (elig0 | elig1)) begin
        gnt_q <= pick1;
        prio_q <= ~pick1;
        addr_q <= pick1 ? req1_addr_i : req0_addr_i;
        wdata_q <= pick1 ? req1_wdata_i : req0_wdata_i;
        write_q <= pick1 ? req1_write_i : req0_write_i;
      end
      if (state_q == SETUP) cnt_q <= '0;
      else if (state_q == ACCESS && !PREADY) cnt_q <= cnt_q + 1'b1;
      done0_q <= finish & ~gnt_q;
      done1_q <= finish & gnt_q;
      err0_q <= finish & ~gnt_q & fin_err;
      err1_q <= finish & gnt_q & fin_err;
      rdata0_q <= (finish & ~gnt_q) ? fin_rdata : 32'h0;
      rdata1_q <= (finish & gnt_q) ? fin_rdata : 32'h0;
    end
  assign PADDR = addr_q;
  assign PWDATA = wdata_q;
  assign PWRITE = write_q;
  assign PSEL = psel_q;
  assign PENABLE = penable_q;
  assign busy_o = psel_q;
  assign done0_o = done0_q;
  assign done1_o = done1_q;
  assign req0_rdata_o = rdata0_q;
  assign req1_rdata_o = rdata1_q;
  assign req0_err_o = err0_q;
  assign req1_err_o = err1_q;
endmodule
